// File: rtl/mem_bist.sv
// Memory BIST engine: writes a data pattern to every word, reads it back and
// compares each word one cycle after its read, reporting count and first failure.
module mem_bist #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    pattern,
  input  logic [31:0]   seed,
  output logic          cyc,
  output logic          we,
  output logic [3:0]    sel,
  output logic [31:0]   addr,
  output logic [31:0]   wdata,
  input  logic [31:0]   rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] fail_addr,
  output logic [31:0]   fail_data
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [31:0]   seed_q, seed_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [15:0]   err_q, err_d;
  logic [AW-1:0] fa_q, fa_d;
  logic [31:0]   fd_q, fd_d;
  logic [31:0]   exp_wr, exp_rd;

  function automatic logic [31:0] exp_fn(
    input logic [1:0]  p,
    input logic [31:0] s,
    input logic [31:0] a
  );
    logic [31:0] r;
    unique case (p)
      2'd0:    r = a;
      2'd1:    r = ~a;
      2'd2:    r = s;
      default: r = a[0] ? ~s : s;
    endcase
    return r;
  endfunction

  assign exp_wr = exp_fn(pat_q, seed_q, 32'(cnt_q));
  assign exp_rd = exp_fn(pat_q, seed_q, 32'(cmp_addr_q));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    seed_d     = seed_q;
    cmp_vld_d  = 1'b0;
    cmp_addr_d = cmp_addr_q;
    err_d      = err_q;
    fa_d       = fa_q;
    fd_d       = fd_q;

    if (cmp_vld_q && (rdata != exp_rd)) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0) begin
        fa_d = cmp_addr_q;
        fd_d = rdata;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pat_d   = pattern;
          seed_d  = seed;
          err_d   = 16'd0;
          fa_d    = '0;
          fd_d    = 32'd0;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READ: begin
        cmp_vld_d  = 1'b1;
        cmp_addr_d = cnt_q;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pat_q      <= 2'd0;
      seed_q     <= 32'd0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      err_q      <= 16'd0;
      fa_q       <= '0;
      fd_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      seed_q     <= seed_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      err_q      <= err_d;
      fa_q       <= fa_d;
      fd_q       <= fd_d;
    end
  end

  assign cyc       = (state_q == WRITE) || (state_q == READ);
  assign we        = (state_q == WRITE);
  assign sel       = cyc ? 4'hF : 4'h0;
  assign addr      = cyc ? 32'(cnt_q) : 32'd0;
  assign wdata     = we ? exp_wr : 32'd0;
  assign busy      = cyc || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 16'd0);
  assign err_count = err_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: pairs it with a 1-cycle-latency byte-enabled RAM
// that can inject read faults, and checks results against hand-computed values.
module tb_mem_bist;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [31:0] seed = 32'd0;
  logic        cyc, we, busy, done, pass;
  logic [3:0]  sel;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] err_count;
  logic [7:0]  fail_addr;
  logic [31:0] fail_data;

  int n_chk = 0;
  int n_err = 0;

  mem_bist #(.WORDS(256), .AW(8)) dut (
    .ck(ck), .rst_n(rst_n), .start(start), .pattern(pattern), .seed(seed),
    .cyc(cyc), .we(we), .sel(sel), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 ck = ~ck;

  // RAM: fault 0 = clean, 1 = bit 4 of word 17 reads as 1, 2 = read stuck at 0
  logic [31:0] mem [256];
  logic [31:0] rd_q = 32'd0;
  int          fault = 0;
  assign rdata = rd_q;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;

  always @(posedge ck) begin
    if (cyc && we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem[addr[7:0]][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (cyc && !we) begin
      if (fault == 2)
        rd_q <= 32'd0;
      else if (fault == 1 && addr[7:0] == 8'd17)
        rd_q <= mem[addr[7:0]] | 32'h10;
      else
        rd_q <= mem[addr[7:0]];
    end
  end

  // Continuous protocol checks
  always @(negedge ck) begin
    n_chk++;
    if ((sel == 4'hF) != cyc || (sel != 4'hF && sel != 4'h0)) begin
      n_err++;
      $display("FAIL sel_vs_cyc: sel=%h cyc=%0b", sel, cyc);
    end
    if (cyc && addr >= 32'd256) begin
      n_err++;
      $display("FAIL addr_range: addr=%0d required <256", addr);
    end
    if (busy && done) begin
      n_err++;
      $display("FAIL busy_done: both high");
    end
    if (pass && !done) begin
      n_err++;
      $display("FAIL pass_wo_done: pass=1 done=0");
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_start(input logic [1:0] p, input logic [31:0] s);
    @(negedge ck);
    pattern = p;
    seed    = s;
    start   = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, {31'd0, cyc}, 32'd0);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_sel"}, {28'd0, sel}, 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_errc"}, {16'd0, err_count}, 32'd0);
    chk({tag, "_faddr"}, {24'd0, fail_addr}, 32'd0);
    chk({tag, "_fdata"}, fail_data, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  pat;
    logic [31:0] sd;
    int          flt;
    logic [15:0] e_err;
    logic [7:0]  e_fa;
    logic [31:0] e_fd;
    logic        e_pass;
    logic [31:0] e_m200;
    logic [31:0] e_m17;
  } vec_t;

  vec_t vt [5];

  initial begin
    int n;
    int k;

    vt[0] = '{2'd0, 32'h0, 0, 16'd0, 8'd0, 32'h0, 1'b1,
              32'd200, 32'd17};
    vt[1] = '{2'd3, 32'hA5A5_5A5A, 1, 16'd1, 8'd17, 32'h5A5A_A5B5, 1'b0,
              32'hA5A5_5A5A, 32'h5A5A_A5A5};
    vt[2] = '{2'd1, 32'h0, 2, 16'd256, 8'd0, 32'h0, 1'b0,
              32'hFFFF_FF37, 32'hFFFF_FFEE};
    vt[3] = '{2'd2, 32'h1234_5678, 0, 16'd0, 8'd0, 32'h0, 1'b1,
              32'h1234_5678, 32'h1234_5678};
    vt[4] = '{2'd3, 32'h0, 2, 16'd128, 8'd1, 32'h0, 1'b0,
              32'h0, 32'hFFFF_FFFF};

    // Reset has priority over a simultaneous start
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk_all_zero("reset");
    @(negedge ck);
    rst_n = 1'b1;
    tick();

    // Table-driven full runs; each start after the first comes from DONE
    for (int i = 0; i < 5; i++) begin
      fault = vt[i].flt;
      do_start(vt[i].pat, vt[i].sd);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_pass_lo", i), {31'd0, pass}, 32'd0);
      wait_done(n);
      chk($sformatf("v%0d_latency", i), n, 32'd513);
      chk($sformatf("v%0d_errc", i), {16'd0, err_count}, {16'd0, vt[i].e_err});
      chk($sformatf("v%0d_faddr", i), {24'd0, fail_addr}, {24'd0, vt[i].e_fa});
      chk($sformatf("v%0d_fdata", i), fail_data, vt[i].e_fd);
      chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vt[i].e_pass});
      chk($sformatf("v%0d_mem200", i), mem[200], vt[i].e_m200);
      chk($sformatf("v%0d_mem17", i), mem[17], vt[i].e_m17);
      tick();
      tick();
      chk($sformatf("v%0d_hold", i), {15'd0, done, err_count},
          {15'd1, vt[i].e_err});
    end

    // Reset at write address 100 abandons the run
    fault = 2;
    do_start(2'd0, 32'h0);
    k = 0;
    while (!(cyc && we && addr == 32'd100) && k < 1000) begin
      tick();
      k++;
    end
    chk("rst_mid_reach", {31'd0, (k < 1000)}, 32'd1);
    @(negedge ck);
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    @(negedge ck);
    rst_n = 1'b1;
    fault = 0;
    tick();
    chk("rst_mid_idle", {31'd0, busy}, 32'd0);
    do_start(2'd0, 32'h0);
    wait_done(n);
    chk("rst_fresh_lat", n, 32'd513);
    chk("rst_fresh_pass", {31'd0, pass}, 32'd1);
    chk("rst_fresh_errc", {16'd0, err_count}, 32'd0);

    // Start pulsed during READ is ignored; error run first so clean rerun shows clear
    fault = 1;
    do_start(2'd3, 32'hA5A5_5A5A);
    wait_done(n);
    chk("pre_errc", {16'd0, err_count}, 32'd1);
    fault = 0;
    do_start(2'd1, 32'h0);
    for (int j = 0; j < 299; j++) tick();
    chk("mid_read", {30'd0, cyc, we}, 32'd2);
    @(negedge ck);
    pattern = 2'd2;
    seed    = 32'hDEAD_BEEF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_done(k);
    chk("ign_latency", 300 + k, 32'd513);
    chk("ign_pass", {31'd0, pass}, 32'd1);
    chk("ign_errc", {16'd0, err_count}, 32'd0);
    chk("ign_mem200", mem[200], 32'hFFFF_FF37);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
